// File: rtl/memory_mdr_responder_if.sv
// Bus bundle between the LC-3 control/datapath side and the memory responder.
// The slave modport is the responder; the master modport is the datapath/RAM/IO side.
interface memory_mdr_responder_if;
    logic [15:0] bus_in;
    logic        ld_mar;
    logic        ld_mdr;
    logic        mio_en;
    logic        r_w;
    logic        gate_mdr;
    logic [15:0] mdr_out;
    logic        mem_ready;
    logic [15:0] ram_addr;
    logic [15:0] ram_wdata;
    logic        ram_we;
    logic        ram_re;
    logic [15:0] ram_rdata;
    logic        kb_strobe;
    logic [7:0]  kb_char;
    logic        ddr_valid;
    logic [7:0]  ddr_data;
    logic        ddr_ack;

    modport slave (
        input  bus_in, ld_mar, ld_mdr, mio_en, r_w, gate_mdr, ram_rdata,
               kb_strobe, kb_char, ddr_ack,
        output mdr_out, mem_ready, ram_addr, ram_wdata, ram_we, ram_re,
               ddr_valid, ddr_data
    );

    modport master (
        output bus_in, ld_mar, ld_mdr, mio_en, r_w, gate_mdr, ram_rdata,
               kb_strobe, kb_char, ddr_ack,
        input  mdr_out, mem_ready, ram_addr, ram_wdata, ram_we, ram_re,
               ddr_valid, ddr_data
    );
endinterface

// File: rtl/memory_mdr_responder.sv
// Memory-side MAR/MDR responder: RAM accesses with fixed latency plus the
// keyboard/display memory-mapped registers, with a one-cycle ready pulse.
module memory_mdr_responder #(
    parameter int          MEM_LATENCY  = 3,
    parameter logic [15:0] KB_ADDR_BASE = 16'hFE00
) (
    input logic                    clk,
    input logic                    rst,
    memory_mdr_responder_if.slave  mem_bus
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;

    localparam logic [1:0] SEL_KBSR = 2'd0;
    localparam logic [1:0] SEL_KBDR = 2'd1;
    localparam logic [1:0] SEL_DSR  = 2'd2;
    localparam logic [1:0] SEL_DDR  = 2'd3;

    localparam logic [3:0] LAST_CNT = 4'(MEM_LATENCY - 1);

    logic [1:0]  r_state;
    logic [15:0] r_mar;
    logic [15:0] r_mdr;
    logic        r_kbsr_ready;
    logic [7:0]  r_kbdr;
    logic        r_dsr_ready;
    logic        r_is_write;
    logic        r_mmio;
    logic [3:0]  r_cnt;
    logic        r_ddr_valid;
    logic [7:0]  r_ddr_data;

    logic        w_mmio_hit;
    logic [1:0]  w_sel;
    logic        w_ram_access;
    logic        w_last;

    // Only even addresses inside the 8-byte block decode as MMIO; odd ones fall through to RAM.
    assign w_mmio_hit   = (r_mar[15:3] == KB_ADDR_BASE[15:3]) && !r_mar[0];
    assign w_sel        = r_mar[2:1];
    assign w_ram_access = (r_state == S_ACCESS) && !r_mmio;
    assign w_last       = (r_cnt == LAST_CNT);

    // NOTE: all state below uses non-blocking assignments so every register
    // samples pre-edge values; later assignments in the block win on conflict.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_mar        <= 16'h0000;
            r_mdr        <= 16'h0000;
            r_kbsr_ready <= 1'b0;
            r_kbdr       <= 8'h00;
            r_dsr_ready  <= 1'b1;
            r_is_write   <= 1'b0;
            r_mmio       <= 1'b0;
            r_cnt        <= 4'd0;
            r_ddr_valid  <= 1'b0;
            r_ddr_data   <= 8'h00;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (mem_bus.ld_mar) r_mar <= mem_bus.bus_in;
                    if (mem_bus.ld_mdr) r_mdr <= mem_bus.bus_in;
                    if (mem_bus.mio_en) begin
                        r_state    <= S_ACCESS;
                        r_is_write <= mem_bus.r_w;
                        r_mmio     <= w_mmio_hit;
                        r_cnt      <= 4'd0;
                    end
                end
                S_ACCESS: begin
                    if (r_mmio) begin
                        r_state <= S_DONE;
                        if (!r_is_write) begin
                            case (w_sel)
                                SEL_KBSR: r_mdr <= {r_kbsr_ready, 15'b0};
                                SEL_KBDR: begin
                                    r_mdr        <= {8'h00, r_kbdr};
                                    r_kbsr_ready <= 1'b0;
                                end
                                SEL_DSR:  r_mdr <= {r_dsr_ready, 15'b0};
                                default:  r_mdr <= 16'h0000;
                            endcase
                        end else if (w_sel == SEL_DDR && r_dsr_ready) begin
                            r_ddr_data  <= r_mdr[7:0];
                            r_ddr_valid <= 1'b1;
                            r_dsr_ready <= 1'b0;
                        end
                    end else if (w_last) begin
                        if (!r_is_write) r_mdr <= mem_bus.ram_rdata;
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase

            // DSR is cleared only while ddr_valid is low, so ack and DDR write never collide.
            if (mem_bus.ddr_ack && r_ddr_valid) begin
                r_ddr_valid <= 1'b0;
                r_dsr_ready <= 1'b1;
            end

            // Placed after the KBDR read so a same-cycle strobe keeps the ready flag set.
            if (mem_bus.kb_strobe) begin
                r_kbdr       <= mem_bus.kb_char;
                r_kbsr_ready <= 1'b1;
            end
        end
    end

    assign mem_bus.mdr_out   = mem_bus.gate_mdr ? r_mdr : 16'hzzzz;
    assign mem_bus.mem_ready = (r_state == S_DONE);
    assign mem_bus.ram_addr  = r_mar;
    assign mem_bus.ram_wdata = r_mdr;
    assign mem_bus.ram_re    = w_ram_access && !r_is_write;
    assign mem_bus.ram_we    = w_ram_access && r_is_write && (r_cnt == 4'd0);
    assign mem_bus.ddr_valid = r_ddr_valid;
    assign mem_bus.ddr_data  = r_ddr_data;

endmodule
